// File: rtl/axis_x_source.sv
// axis_x_source: AXI-Stream master that holds a small list of 64-bit double
// operands and streams them, one beat per stored word, after a start pulse.
// Optional feature macro: AXIS_X_SOURCE_LOOP_EN adds a `loop` input that
// wraps from the final entry back to entry 0 without a bubble.
module axis_x_source #(
  parameter int DEPTH     = 8,
  parameter int LAST_EACH = 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
`ifdef AXIS_X_SOURCE_LOOP_EN
  input  logic          loop,
`endif
  input  logic          wr_en,
  input  logic [63:0]   wr_data,
  input  logic          start,
  input  logic          clear,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic [CW-1:0] count,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [63:0]   m_tdata,
  output logic          m_tlast
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [63:0]   tdata_q, tdata_d;
  logic          tlast_q, tlast_d;

  // Operand storage; read ports feed the output register only.
  logic [63:0]   mem [DEPTH];
  logic          mem_we;
  logic [IW-1:0] mem_waddr;

  logic          loop_w;
  logic          count_full;
  logic          wr_ok;
  logic [CW-1:0] count_eff;
  logic          bypass0;
  logic          last_beat;
  logic [IW-1:0] nidx;

`ifdef AXIS_X_SOURCE_LOOP_EN
  assign loop_w = loop;
`else
  assign loop_w = 1'b0;
`endif

  // TLAST for the entry at position pos of a list holding cnt words.
  function automatic logic last_flag(input logic [CW-1:0] pos, input logic [CW-1:0] cnt);
    return (LAST_EACH != 0) ? 1'b1 : (pos == cnt - CW'(1));
  endfunction

  // A write accepted in IDLE is counted before a same-cycle start, so the
  // stream includes it; entry 0 written this cycle is bypassed from wr_data.
  assign count_full = (count_q == CW'(DEPTH));
  assign wr_ok      = wr_en && !count_full;
  assign count_eff  = count_q + CW'(wr_ok);
  assign bypass0    = wr_ok && (count_q == '0);
  assign last_beat  = (CW'(idx_q) == count_q - CW'(1));
  assign nidx       = idx_q + IW'(1);

  // Buffer write port (no reset: emptiness is tracked by count).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= wr_data;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      overflow_q <= 1'b0;
      idx_q      <= '0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      idx_q      <= idx_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!clear && start && (count_eff != '0)) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (m_tready && last_beat && !loop_w) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Buffer bookkeeping and output-register loading.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    idx_d      = idx_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    mem_we     = 1'b0;
    mem_waddr  = count_q[IW-1:0];
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          count_d    = '0;
          overflow_d = 1'b0;
        end else begin
          if (wr_en) begin
            if (count_full) begin
              overflow_d = 1'b1;
            end else begin
              mem_we  = 1'b1;
              count_d = count_q + CW'(1);
            end
          end
          if (start && (count_eff != '0)) begin
            idx_d   = '0;
            tdata_d = bypass0 ? wr_data : mem[0];
            tlast_d = last_flag('0, count_eff);
          end
        end
      end
      S_STREAM: begin
        if (wr_en) begin
          overflow_d = 1'b1;
        end
        // Next entry loads on the accepting edge so beats are back to back.
        if (m_tready) begin
          if (!last_beat) begin
            idx_d   = nidx;
            tdata_d = mem[nidx];
            tlast_d = last_flag(CW'(nidx), count_q);
          end else if (loop_w) begin
            idx_d   = '0;
            tdata_d = mem[0];
            tlast_d = last_flag('0, count_q);
          end
        end
      end
      S_DONE: begin
        if (wr_en) begin
          overflow_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from registered state only (TVALID has no TREADY path).
  always_comb begin
    m_tvalid = (state_q == S_STREAM);
    busy     = (state_q == S_STREAM);
    done     = (state_q == S_DONE);
  end

  assign m_tdata  = tdata_q;
  assign m_tlast  = tlast_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_axis_x_source.sv
// Testbench for axis_x_source: two instances (TLAST every beat / TLAST on
// final word) share one stimulus; a negedge monitor compares both against a
// list-level reference model and a queue of expected beats.
module tb_axis_x_source;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [63:0]   wr_data = '0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          tready = 1'b0;
  logic          loop = 1'b0;

  logic          busy     [2];
  logic          done     [2];
  logic          overflow [2];
  logic [CW-1:0] count    [2];
  logic          tvalid   [2];
  logic [63:0]   tdata    [2];
  logic          tlast    [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    axis_x_source #(.DEPTH(DEPTH), .LAST_EACH((gi == 0) ? 1 : 0)) u_dut (
      .clk      (clk),
      .rst      (rst),
`ifdef AXIS_X_SOURCE_LOOP_EN
      .loop     (loop),
`endif
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .start    (start),
      .clear    (clear),
      .busy     (busy[gi]),
      .done     (done[gi]),
      .overflow (overflow[gi]),
      .count    (count[gi]),
      .m_tvalid (tvalid[gi]),
      .m_tready (tready),
      .m_tdata  (tdata[gi]),
      .m_tlast  (tlast[gi])
    );
  end

  // Reference model: the stored list, the sticky overflow flag, and the
  // beats still owed to the slave.
  typedef struct {
    logic [63:0] data;
    int          idx;
    bit          fin;
  } beat_t;

  logic [63:0] list[$];
  bit          ovf_m = 1'b0;
  beat_t       q[$];
  bit          done_exp = 1'b0;
  bit          rst_prev = 1'b0;

  int errors = 0;
  int checks = 0;

  bit bp_rand = 1'b0;
  int bp_idx  = -1;
  int hold    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every cycle, consume a beat when the DUT presents one
  // and the slave accepts it.
  always @(negedge clk) begin
    bit    exp_v;
    bit    done_n;
    beat_t b;
    exp_v  = (q.size() > 0);
    done_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("tvalid%0d", d), 64'(tvalid[d]), 64'(exp_v));
      check($sformatf("busy%0d", d), 64'(busy[d]), 64'(exp_v));
      check($sformatf("done%0d", d), 64'(done[d]), 64'(done_exp));
      check($sformatf("count%0d", d), 64'(count[d]), 64'(list.size()));
      check($sformatf("overflow%0d", d), 64'(overflow[d]), 64'(ovf_m));
      if (exp_v) begin
        check($sformatf("tdata%0d", d), tdata[d], q[0].data);
        check($sformatf("tlast%0d", d), 64'(tlast[d]), (d == 0) ? 64'd1 : 64'(q[0].fin));
      end
      if (rst_prev) begin
        check($sformatf("rst_tdata%0d", d), tdata[d], 64'd0);
        check($sformatf("rst_tlast%0d", d), 64'(tlast[d]), 64'd0);
      end
    end
    if (!rst && exp_v && tready) begin
      b = q.pop_front();
      $display("beat idx=%0d data=%h tlast=%b/%b", b.idx, tdata[0], tlast[0], tlast[1]);
      if (b.fin) begin
        if (loop) begin
          for (int i = 0; i < list.size(); i++) q.push_back('{list[i], i, i == list.size() - 1});
        end else begin
          done_n = 1'b1;
        end
      end
    end
    if (rst) begin
      q.delete();
      done_n = 1'b0;
    end
    done_exp = done_n;
    rst_prev = rst;
  end

  // Slave-side TREADY: random, held low for 3 cycles on a chosen beat, or 1.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_rand) begin
        tready = ($urandom_range(0, 3) != 0);
      end else if (bp_idx >= 0 && q.size() > 0 && q[0].idx == bp_idx && hold < 3) begin
        tready = 1'b0;
        hold++;
      end else begin
        if (q.size() == 0 || q[0].idx != bp_idx) hold = 0;
        tready = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of control inputs and update the model to match.
  task automatic apply(input bit w, input logic [63:0] dat, input bit s, input bit c);
    bit busy_m;
    busy_m  = (q.size() > 0) || done_exp;
    wr_en   = w;
    wr_data = dat;
    start   = s;
    clear   = c;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    if (busy_m) begin
      if (w) ovf_m = 1'b1;
    end else if (c) begin
      list.delete();
      ovf_m = 1'b0;
    end else begin
      if (w) begin
        if (list.size() < DEPTH) list.push_back(dat);
        else ovf_m = 1'b1;
      end
      if (s) begin
        for (int i = 0; i < list.size(); i++) q.push_back('{list[i], i, i == list.size() - 1});
      end
    end
  endtask

  task automatic write(input logic [63:0] dat);
    apply(1'b1, dat, 1'b0, 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() > 0 || done_exp) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      $display("FAIL stream_timeout got=busy want=idle t=%0t", $time);
      $fatal(1, "stream did not finish");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    list.delete();
    ovf_m = 1'b0;
  endtask

  task automatic load4();
    apply(1'b0, '0, 1'b0, 1'b1);
    write(64'h4000000000000000);
    write(64'h3FF0000000000000);
    write(64'h4024000000000000);
    write(64'hBFF0000000000000);
  endtask

  initial begin
    tick();
    do_reset();
    repeat (3) tick();

    // Basic stream, then replay of the same list.
    load4();
    apply(1'b0, '0, 1'b1, 1'b0);
    wait_idle();
    apply(1'b0, '0, 1'b1, 1'b0);
    wait_idle();

    // Backpressure on the second beat.
    bp_idx = 1;
    apply(1'b0, '0, 1'b1, 1'b0);
    wait_idle();
    bp_idx = -1;

    // Overflow: nine writes into eight entries, then stream, then clear.
    apply(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) write({$urandom, $urandom});
    apply(1'b0, '0, 1'b1, 1'b0);
    wait_idle();
    apply(1'b0, '0, 1'b0, 1'b1);
    tick();

    // Write while streaming is dropped and flags overflow.
    write(64'h1111);
    write(64'h2222);
    write(64'h3333);
    apply(1'b0, '0, 1'b1, 1'b0);
    apply(1'b1, 64'h4444, 1'b0, 1'b0);
    wait_idle();

    // Reset after beat 2 of 4; a later start must be ignored.
    load4();
    apply(1'b0, '0, 1'b1, 1'b0);
    for (int n = 0; n < 50 && q.size() > 2; n++) tick();
    do_reset();
    apply(1'b0, '0, 1'b1, 1'b0);
    repeat (4) tick();

    // Clear beats start.
    write(64'hAAAA);
    write(64'hBBBB);
    apply(1'b0, '0, 1'b1, 1'b1);
    repeat (4) tick();

    // Write together with start, from empty and from a partial list.
    apply(1'b1, 64'h5555, 1'b1, 1'b0);
    wait_idle();
    write(64'h6666);
    apply(1'b1, 64'h7777, 1'b1, 1'b0);
    wait_idle();

`ifdef AXIS_X_SOURCE_LOOP_EN
    // Loop over two words, then let the current pass finish.
    apply(1'b0, '0, 1'b0, 1'b1);
    write(64'h4000000000000000);
    write(64'h3FF0000000000000);
    loop = 1'b1;
    apply(1'b0, '0, 1'b1, 1'b0);
    repeat (7) tick();
    loop = 1'b0;
    wait_idle();
`endif

    // Randomized lists, writes, starts and backpressure.
    for (int it = 0; it < 40; it++) begin
      bp_rand = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) apply(1'b0, '0, 1'b0, 1'b1);
      for (int k = $urandom_range(0, 4); k > 0; k--) write({$urandom, $urandom});
      apply(($urandom_range(0, 2) == 0), {$urandom, $urandom}, 1'b1, 1'b0);
      if ($urandom_range(0, 2) == 0) apply(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
      wait_idle();
      tick();
    end
    bp_rand = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_x_source.md
# axis_x_source

AXI-Stream master that buffers a programmed list of IEEE-754 double `x` operands and streams them to the slave (`ab`) input of the cubic evaluator. It is the transmit end of the operand interface. It gives the datapath a synthesizable, backpressure-correct driver in place of the bench-side task. Software or a controller loads words through a simple write port, pulses `start`, and the block emits one beat per stored word with full AXI-Stream valid/ready semantics.

## Interface
- `DEPTH`, 8: number of buffer entries, ≥2.
- `LAST_EACH`, 1: 1 asserts TLAST on every beat (one-beat packets); 0 asserts TLAST only on the final stored word.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  write `wr_data` into the next free entry.
- `wr_data`  in  64  double-precision bit pattern (raw `$realtobits` encoding).
- `start`  in  1  one-cycle request to stream the buffer contents.
- `clear`  in  1  empty the buffer (count←0).
- `busy`  out  1  high while streaming.
- `done`  out  1  one-cycle pulse after the last beat is accepted.
- `overflow`  out  1  sticky: a write was dropped; cleared by `clear` or `rst`.
- `count`  out  $clog2(DEPTH+1)  entries currently stored.
- `m_tvalid`  out  1  AXI-Stream TVALID.
- `m_tready`  in  1  AXI-Stream TREADY.
- `m_tdata`  out  64  AXI-Stream TDATA.
- `m_tlast`  out  1  AXI-Stream TLAST.

## Operation
- States: IDLE, STREAM, DONE.
- IDLE:
  - `wr_en` with count<DEPTH writes the entry at index count and increments count.
  - `wr_en` with count==DEPTH drops the word and sets overflow.
  - `clear` sets count←0 and overflow←0.
  - `start` with count>0 loads index 0 into the output register and moves to STREAM.
  - `start` with count==0 is ignored.
- STREAM: `m_tvalid`=1 and `busy`=1.
  - A beat transfers on an edge with `m_tvalid && m_tready`.
  - On transfer of a non-final beat, the next entry loads into `m_tdata`/`m_tlast` on the same edge, so there are no bubbles.
  - On transfer of the final beat (index count-1), go to DONE.
  - `wr_en` in STREAM or DONE is dropped and sets overflow.
  - `clear` and `start` are ignored outside IDLE.
- DONE: `done`=1 for exactly one cycle, `m_tvalid`=0, then return to IDLE.
- Buffer contents and count persist after DONE, so a second `start` replays the same list.
- Data is passed bit-exact; the block performs no arithmetic on the data.
- TLAST per `LAST_EACH`.
- Same-cycle priority in IDLE:
  - `clear` beats `start` and `wr_en`; both are ignored.
  - `wr_en` together with `start`: the write lands first, and the stream includes the new word.

## Timing
- Reset values:
  - `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0
  - `busy`=0, `done`=0, `overflow`=0, `count`=0
  - state IDLE
- Latency: `start` sampled at edge N puts `m_tvalid`=1 with entry 0 after edge N, so it is visible in cycle N+1.
- With `m_tready` held 1, K words occupy K consecutive cycles. `done` is high in the cycle after the K-th transfer.
- While `m_tvalid`=1 and `m_tready`=0, `m_tdata` and `m_tlast` hold stable. `m_tvalid` never deasserts before a transfer except on `rst`.
- `m_tvalid` does not depend combinationally on `m_tready`.
- `rst` mid-stream: all outputs reach reset values after the next edge, and the buffer is emptied. This is the only permitted TVALID withdrawal.

## Configuration
- `AXIS_X_SOURCE_LOOP_EN` defined:
  - Adds input port `loop` (1 bit).
  - In STREAM, if `loop`=1 when the final beat transfers, entry 0 loads on the same edge and streaming continues with no bubble; `done` does not pulse.
  - Deasserting `loop` lets the current pass finish normally.
- Not defined: the `loop` port is absent, and every pass ends in DONE.

## Test plan
- Basic stream:
  - Stimulus: write 0x4000000000000000, 0x3FF0000000000000, 0x4024000000000000, 0xBFF0000000000000 (2.0, 1.0, 10.0, -1.0); `start`; `m_tready`=1.
  - Response: 4 beats on consecutive cycles in order, `m_tlast`=1 each beat, `done` one cycle after beat 4, `count` stays 4.
- Backpressure:
  - Stimulus: same load; `m_tready`=0 for 3 cycles while beat 2 is presented.
  - Response: `m_tdata`=0x3FF0000000000000 and `m_tvalid`=1 held stable throughout; no beat lost or duplicated.
- Overflow:
  - Stimulus: DEPTH=8; write 9 words, then `start`.
  - Response: `count`=8, `overflow`=1, only the first 8 words stream.
  - Then: `clear` → `count`=0, `overflow`=0.
- Replay and TLAST mode:
  - Stimulus: with `LAST_EACH`=0, the basic stream run, then a second `start`.
  - Response: `m_tlast` only on 0xBFF0000000000000 in each pass; the second pass is identical to the first.
- Reset and priority:
  - Stimulus: `rst` after beat 2 of 4.
  - Response: `m_tvalid`=0 and `count`=0 next cycle; a later `start` is ignored.
  - Stimulus: `clear` together with `start`.
  - Response: no stream.
- Loop (macro defined):
  - Stimulus: `loop`=1, 2 words loaded, `m_tready`=1.
  - Response: the pattern w0,w1,w0,w1,… repeats with no gaps.
  - Then: drop `loop` → current pass ends and `done` pulses once.
